sum_display: RTL and testbench

Downstream stage of the 4-bit adder: takes the 5-bit result {carry-out, 4-bit sum}, converts it to two BCD digits with an iterative double-dabble engine, and drives a 2-digit multiplexed common-anode 7-segment display. It sits between the adder outputs and the board display pins. A start/busy/done handshake controls conversion. The display holds the last converted result until the next conversion completes.

---
 rtl/sum_display_pkg.sv | 62 ++++++
 rtl/sum_display_seg7_decoder.sv | 41 ++++
 rtl/sum_display.sv | 192 +++++++++++++++++++
 tb/tb_sum_display.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/sum_display_pkg.sv
// sum_display_pkg: shared types, widths and segment patterns for the
// sum_display block (adder result -> BCD -> 2-digit 7-segment display).
// Optional feature macro: SUM_DISPLAY_HEX_EN (hex digits, no double-dabble).
package sum_display_pkg;

    // Conversion controller states
    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    // Datapath widths
    localparam int BIN_W   = 5;
    localparam int BCD_W   = 4;
    localparam int ITER    = 5;
    localparam int CNT_W   = 3;
    localparam int SHIFT_W = 2 * BCD_W + BIN_W;

    // Anode patterns (active-low): an[0] drives ones, an[1] drives tens
    localparam logic [1:0] AN_ONES = 2'b10;
    localparam logic [1:0] AN_TENS = 2'b01;

    // Active-low segment patterns, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_A     = 7'b0001000;
    localparam logic [6:0] SEG_B     = 7'b0000011;
    localparam logic [6:0] SEG_C     = 7'b1000110;
    localparam logic [6:0] SEG_D     = 7'b0100001;
    localparam logic [6:0] SEG_E     = 7'b0000110;
    localparam logic [6:0] SEG_F     = 7'b0001110;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // One double-dabble iteration on {tens, ones, bin}: add 3 to every BCD
    // nibble that is 5 or more, then shift the whole register left by one.
    function automatic logic [SHIFT_W-1:0] dd_step(input logic [SHIFT_W-1:0] r);
        logic [BCD_W-1:0] tens;
        logic [BCD_W-1:0] ones;
        tens = r[SHIFT_W-1 -: BCD_W];
        ones = r[BIN_W +: BCD_W];
        if (tens >= 4'd5) begin
            tens = tens + 4'd3;
        end else begin
            tens = tens;
        end
        if (ones >= 4'd5) begin
            ones = ones + 4'd3;
        end else begin
            ones = ones;
        end
        return {tens[BCD_W-2:0], ones, r[BIN_W-1:0], 1'b0};
    endfunction

endpackage

// File: rtl/sum_display_seg7_decoder.sv
// seg7_decoder: combinational 4-bit digit -> active-low 7-segment pattern.
// With SUM_DISPLAY_HEX_EN defined, codes 10-15 show A-F; otherwise blank.
import sum_display_pkg::*;

module seg7_decoder (
    input  logic [BCD_W-1:0] digit,
    input  logic             blank,
    output logic [6:0]       seg
);

    // Map the digit to its segment pattern, forcing blank when requested
    always_comb begin
        seg = SEG_BLANK;
        if (blank) begin
            seg = SEG_BLANK;
        end else begin
            case (digit)
                4'd0:    seg = SEG_0;
                4'd1:    seg = SEG_1;
                4'd2:    seg = SEG_2;
                4'd3:    seg = SEG_3;
                4'd4:    seg = SEG_4;
                4'd5:    seg = SEG_5;
                4'd6:    seg = SEG_6;
                4'd7:    seg = SEG_7;
                4'd8:    seg = SEG_8;
                4'd9:    seg = SEG_9;
`ifdef SUM_DISPLAY_HEX_EN
                4'd10:   seg = SEG_A;
                4'd11:   seg = SEG_B;
                4'd12:   seg = SEG_C;
                4'd13:   seg = SEG_D;
                4'd14:   seg = SEG_E;
                4'd15:   seg = SEG_F;
`endif
                default: seg = SEG_BLANK;
            endcase
        end
    end

endmodule

// File: rtl/sum_display.sv
// sum_display: converts the 5-bit adder result {cout, sum4} to two BCD
// digits (iterative double-dabble, start/busy/done handshake) and scans them
// onto a 2-digit common-anode 7-segment display.
// Optional feature macro: SUM_DISPLAY_HEX_EN (single-cycle hex split instead
// of double-dabble; decoder adds A-F).
import sum_display_pkg::*;

module sum_display #(
    parameter int REFRESH_DIV = 50000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [BIN_W-1:0] value,
    output logic             busy,
    output logic             done,
    output logic [BCD_W-1:0] bcd_tens,
    output logic [BCD_W-1:0] bcd_ones,
    output logic [6:0]       seg,
    output logic [1:0]       an
);

    localparam int SCAN_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [SCAN_W-1:0] SCAN_MAX = SCAN_W'(REFRESH_DIV - 1);

    state_t               state;
    state_t               state_nxt;
    logic [SHIFT_W-1:0]   shreg;
    logic [SHIFT_W-1:0]   shreg_nxt;
    logic [CNT_W-1:0]     cnt;
    logic [CNT_W-1:0]     cnt_nxt;
    logic                 busy_nxt;
    logic                 done_nxt;
    logic [BCD_W-1:0]     tens_nxt;
    logic [BCD_W-1:0]     ones_nxt;

    logic [SCAN_W-1:0]    scan_cnt;
    logic [SCAN_W-1:0]    scan_nxt;
    logic [1:0]           an_nxt;
    logic [BCD_W-1:0]     digit_sel;
    logic                 blank_sel;
    logic [6:0]           seg_dec;

    // Conversion state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: one SHIFT pass per iteration, back to IDLE at the end
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nxt = ST_SHIFT;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_SHIFT: begin
`ifdef SUM_DISPLAY_HEX_EN
                state_nxt = ST_IDLE;
`else
                if (cnt == CNT_W'(1)) begin
                    state_nxt = ST_IDLE;
                end else begin
                    state_nxt = ST_SHIFT;
                end
`endif
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Datapath and handshake next values for each state
    always_comb begin
        shreg_nxt = shreg;
        cnt_nxt   = cnt;
        busy_nxt  = busy;
        done_nxt  = 1'b0;
        tens_nxt  = bcd_tens;
        ones_nxt  = bcd_ones;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    shreg_nxt = {{(2 * BCD_W){1'b0}}, value};
                    cnt_nxt   = CNT_W'(ITER);
                    busy_nxt  = 1'b1;
                end else begin
                    busy_nxt  = 1'b0;
                end
            end
            ST_SHIFT: begin
`ifdef SUM_DISPLAY_HEX_EN
                // Hex mode: the result is a plain split of the latched value
                tens_nxt = {3'b000, shreg[BIN_W-1]};
                ones_nxt = shreg[BCD_W-1:0];
                done_nxt = 1'b1;
                busy_nxt = 1'b0;
`else
                shreg_nxt = dd_step(shreg);
                cnt_nxt   = cnt - CNT_W'(1);
                if (cnt == CNT_W'(1)) begin
                    tens_nxt = shreg_nxt[SHIFT_W-1 -: BCD_W];
                    ones_nxt = shreg_nxt[BIN_W +: BCD_W];
                    done_nxt = 1'b1;
                    busy_nxt = 1'b0;
                end else begin
                    busy_nxt = 1'b1;
                end
`endif
            end
            default: begin
                busy_nxt = 1'b0;
            end
        endcase
    end

    // Conversion datapath and result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            shreg    <= {SHIFT_W{1'b0}};
            cnt      <= {CNT_W{1'b0}};
            busy     <= 1'b0;
            done     <= 1'b0;
            bcd_tens <= {BCD_W{1'b0}};
            bcd_ones <= {BCD_W{1'b0}};
        end else begin
            shreg    <= shreg_nxt;
            cnt      <= cnt_nxt;
            busy     <= busy_nxt;
            done     <= done_nxt;
            bcd_tens <= tens_nxt;
            bcd_ones <= ones_nxt;
        end
    end

    // Scan counter wrap and digit toggle
    always_comb begin
        if (scan_cnt == SCAN_MAX) begin
            scan_nxt = {SCAN_W{1'b0}};
            if (an == AN_ONES) begin
                an_nxt = AN_TENS;
            end else begin
                an_nxt = AN_ONES;
            end
        end else begin
            scan_nxt = scan_cnt + SCAN_W'(1);
            if (an == AN_TENS) begin
                an_nxt = AN_TENS;
            end else begin
                an_nxt = AN_ONES;
            end
        end
    end

    // Digit mux on the values that will be registered, so seg always matches
    // the anode and result registers of the same cycle; tens blanks when zero
    always_comb begin
        if (an_nxt == AN_TENS) begin
            digit_sel = tens_nxt;
            blank_sel = (tens_nxt == 4'd0);
        end else begin
            digit_sel = ones_nxt;
            blank_sel = 1'b0;
        end
    end

    seg7_decoder u_seg7_decoder (
        .digit (digit_sel),
        .blank (blank_sel),
        .seg   (seg_dec)
    );

    // Display scan registers; scanning never waits on the converter
    always_ff @(posedge clk) begin
        if (rst) begin
            scan_cnt <= {SCAN_W{1'b0}};
            an       <= AN_ONES;
            seg      <= SEG_0;
        end else begin
            scan_cnt <= scan_nxt;
            an       <= an_nxt;
            seg      <= seg_dec;
        end
    end

endmodule

// File: tb/tb_sum_display.sv
// tb_sum_display: directed plus random stimulus for sum_display, checked
// every cycle against a transaction-level model (value/10, value%10,
// fixed latency, anode phase from elapsed cycles).
module tb_sum_display;

    localparam int DIV = 4;
`ifdef SUM_DISPLAY_HEX_EN
    localparam int LAT = 1;
    localparam bit HEX = 1'b1;
`else
    localparam int LAT = 5;
    localparam bit HEX = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [4:0] value;
    logic       busy;
    logic       done;
    logic [3:0] bcd_tens;
    logic [3:0] bcd_ones;
    logic [6:0] seg;
    logic [1:0] an;

    int checks = 0;
    int errors = 0;

    // reference model state
    bit         m_valid = 1'b0;
    int         m_left  = 0;
    int         m_val   = 0;
    int         m_k     = 0;
    bit         m_done  = 1'b0;
    int         m_tens  = 0;
    int         m_ones  = 0;
    logic [6:0] pat [16];

    sum_display #(.REFRESH_DIV(DIV)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .value    (value),
        .busy     (busy),
        .done     (done),
        .bcd_tens (bcd_tens),
        .bcd_ones (bcd_ones),
        .seg      (seg),
        .an       (an)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [6:0] exp_seg(input logic [1:0] a, input int t, input int o);
        int d;
        if (a == 2'b01) begin
            if (t == 0) return 7'b1111111;
            d = t;
        end else begin
            d = o;
        end
        if (d > 9 && !HEX) return 7'b1111111;
        return pat[d];
    endfunction

    // advance the model over the coming edge, take the edge, then compare
    task automatic tick();
        logic [1:0] a_exp;
        if (rst) begin
            m_valid = 1'b1;
            m_left  = 0;
            m_done  = 1'b0;
            m_tens  = 0;
            m_ones  = 0;
            m_k     = 0;
        end else begin
            m_done = 1'b0;
            if (m_left > 0) begin
                m_left--;
                if (m_left == 0) begin
                    if (HEX) begin
                        m_tens = m_val / 16;
                        m_ones = m_val % 16;
                    end else begin
                        m_tens = m_val / 10;
                        m_ones = m_val % 10;
                    end
                    m_done = 1'b1;
                end
            end else if (start) begin
                m_left = LAT;
                m_val  = int'(value);
            end
            m_k++;
        end
        @(posedge clk);
        #1;
        if (m_valid) begin
            a_exp = (((m_k / DIV) % 2) == 0) ? 2'b10 : 2'b01;
            chk("busy", {7'd0, busy}, {7'd0, (m_left > 0)});
            chk("done", {7'd0, done}, {7'd0, m_done});
            chk("bcd_tens", {4'd0, bcd_tens}, 8'(m_tens));
            chk("bcd_ones", {4'd0, bcd_ones}, 8'(m_ones));
            chk("an", {6'd0, an}, {6'd0, a_exp});
            chk("seg", {1'b0, seg}, {1'b0, exp_seg(a_exp, m_tens, m_ones)});
        end
    endtask

    initial begin
        pat[0]  = 7'b1000000; pat[1]  = 7'b1111001; pat[2]  = 7'b0100100;
        pat[3]  = 7'b0110000; pat[4]  = 7'b0011001; pat[5]  = 7'b0010010;
        pat[6]  = 7'b0000010; pat[7]  = 7'b1111000; pat[8]  = 7'b0000000;
        pat[9]  = 7'b0010000; pat[10] = 7'b0001000; pat[11] = 7'b0000011;
        pat[12] = 7'b1000110; pat[13] = 7'b0100001; pat[14] = 7'b0000110;
        pat[15] = 7'b0001110;

        // reset
        rst = 1'b1; start = 1'b0; value = 5'd0;
        tick(); tick();
        rst = 1'b0;
        chk("rst_seg", {1'b0, seg}, 8'b01000000);
        chk("rst_an", {6'd0, an}, 8'd2);

        // value 31, single-cycle start
        value = 5'd31; start = 1'b1; tick();
        start = 1'b0;
        for (int i = 0; i < LAT; i++) tick();
`ifdef SUM_DISPLAY_HEX_EN
        chk("v31_tens", {4'd0, bcd_tens}, 8'd1);
        chk("v31_ones", {4'd0, bcd_ones}, 8'd15);
`else
        chk("v31_tens", {4'd0, bcd_tens}, 8'd3);
        chk("v31_ones", {4'd0, bcd_ones}, 8'd1);
`endif
        chk("v31_done", {7'd0, done}, 8'd1);
        for (int i = 0; i < 3 * DIV; i++) tick();

        // value 0: tens phase blanked
        value = 5'd0; start = 1'b1; tick();
        start = 1'b0;
        for (int i = 0; i < 3 * DIV + LAT; i++) tick();

        // value 19, second start at N+2 ignored, then 7 at N+6
        value = 5'd19; start = 1'b1; tick();
        start = 1'b0; tick();
        value = 5'd25; start = 1'b1; tick();
        start = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        value = 5'd7; start = 1'b1; tick();
        start = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        chk("v7_ones", {4'd0, bcd_ones}, 8'd7);
        chk("v7_tens", {4'd0, bcd_tens}, 8'd0);
        for (int i = 0; i < 2 * DIV; i++) tick();

        // reset mid-conversion
        value = 5'd23; start = 1'b1; tick();
        start = 1'b0; tick(); tick();
        rst = 1'b1; tick();
        rst = 1'b0;
        chk("abort_busy", {7'd0, busy}, 8'd0);
        chk("abort_seg", {1'b0, seg}, 8'b01000000);
        for (int i = 0; i < 8; i++) tick();

        // start held high: back-to-back conversions
        start = 1'b1;
        for (int i = 0; i < 40; i++) begin
            value = 5'($urandom_range(0, 31));
            tick();
        end
        start = 1'b0;

        // random traffic with occasional reset
        for (int i = 0; i < 600; i++) begin
            value = 5'($urandom_range(0, 31));
            start = ($urandom_range(0, 3) == 0);
            rst   = ($urandom_range(0, 63) == 0);
            tick();
        end
        rst = 1'b0; start = 1'b0;
        for (int i = 0; i < 10; i++) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
